// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the matrix-multiply sequencer.
//   state_e       sequencer FSM states
//   MEM_SEL_*     matrix memory bank selects (A, B, C)
//   MAX_DIM       largest legal dimension N (N*N+1 must fit 8-bit addresses)
//   HDR_IDX       j index that, with i=0, makes address i*N+j+1 wrap to 0
package mm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StClr,
        StAcc,
        StWr,
        StFin
    } state_e;

    localparam logic [2:0] MEM_SEL_A = 3'b000;
    localparam logic [2:0] MEM_SEL_B = 3'b001;
    localparam logic [2:0] MEM_SEL_C = 3'b010;

    localparam int unsigned MAX_DIM = 15;

    localparam logic [7:0] HDR_IDX = 8'hFF;

endpackage

// File: rtl/mm_idx_counter.sv
// mm_idx_counter: the three nested wrap-around indices of the multiply.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   n_i            current dimension N (1..15 while counting)
//   clr_all_i      zero all counters (held while the sequencer is idle)
//   clr_inner_i    zero the inner index
//   inc_inner_i    advance the inner index
//   inc_elem_i     advance col; on col wrap advance row (row wraps too)
//   row_o, col_o, inr_o   current indices
//   last_inner_o   inr == N-1
//   last_elem_o    row == N-1 and col == N-1
module mm_idx_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] n_i,
    input  logic       clr_all_i,
    input  logic       clr_inner_i,
    input  logic       inc_inner_i,
    input  logic       inc_elem_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o,
    output logic [3:0] inr_o,
    output logic       last_inner_o,
    output logic       last_elem_o
);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [3:0] inr_q, inr_d;
    logic [3:0] nm1;

    assign nm1 = n_i - 4'd1;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        inr_d = inr_q;
        if (clr_all_i) begin
            row_d = '0;
            col_d = '0;
            inr_d = '0;
        end else begin
            if (clr_inner_i) begin
                inr_d = '0;
            end else if (inc_inner_i) begin
                inr_d = inr_q + 4'd1;
            end
            if (inc_elem_i) begin
                if (col_q == nm1) begin
                    col_d = '0;
                    row_d = (row_q == nm1) ? 4'd0 : row_q + 4'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
            inr_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            inr_q <= inr_d;
        end
    end

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign inr_o        = inr_q;
    assign last_inner_o = (inr_q == nm1);
    assign last_elem_o  = (row_q == nm1) && (col_q == nm1);

endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: sequences one full C = A*B over the three-bank matrix memory and
// the external MAC unit, writing every element of C and pulsing done.
// Optional feature macro: MM_SEQ_HDR_EN -- when defined, a header cycle copies the
// size word A[0] into C[0] before any product; when undefined, the header cycle is
// omitted and MAC_or_Size is tied 0.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse to begin (ignored while busy)
//   maxSize         dimension N, sampled on the accepted start
//   i, j, k         memory index ports (0 while idle)
//   read, write     memory enables (0 while idle)
//   MemSel          bank select (C on writes)
//   MAC_or_Size     1 = write size header, 0 = write MAC_Result
//   mac_clr, mac_en MAC accumulator clear / accumulate
//   busy            high from the state after the accepted start through done
//   done            one-cycle completion pulse
//   err             set for an illegal N, cleared by the next accepted start
module mm_sequencer #(
    parameter int unsigned MAX_DIM = mm_pkg::MAX_DIM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] maxSize,
    output logic [7:0] i,
    output logic [7:0] j,
    output logic [7:0] k,
    output logic       read,
    output logic       write,
    output logic [2:0] MemSel,
    output logic       MAC_or_Size,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    import mm_pkg::*;

    localparam logic [7:0] MaxDimW = MAX_DIM[7:0];

`ifdef MM_SEQ_HDR_EN
    localparam state_e FirstSt = StHdr;
`else
    localparam state_e FirstSt = StClr;
`endif

    state_e     state_q;
    logic [3:0] n_q;
    logic       err_q;

    logic [3:0] row, col, inr;
    logic       last_inner, last_elem;

    mm_idx_counter u_idx (
        .clk_i        (clk),
        .rst_i        (rst),
        .n_i          (n_q),
        .clr_all_i    (state_q == StIdle),
        .clr_inner_i  (state_q == StClr),
        .inc_inner_i  ((state_q == StAcc) && !last_inner),
        .inc_elem_i   (state_q == StWr),
        .row_o        (row),
        .col_o        (col),
        .inr_o        (inr),
        .last_inner_o (last_inner),
        .last_elem_o  (last_elem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Legal N is at most 15, so the low nibble holds it exactly.
                        n_q   <= maxSize[3:0];
                        err_q <= 1'b0;
                        if (maxSize == 8'd0) begin
                            state_q <= StFin;
                        end else if (maxSize > MaxDimW) begin
                            err_q   <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            state_q <= FirstSt;
                        end
                    end
                end
                StHdr:   state_q <= StClr;
                StClr:   state_q <= StAcc;
                StAcc:   if (last_inner) state_q <= StWr;
                StWr:    state_q <= last_elem ? StFin : StClr;
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs depend only on registered state and counters.
    always_comb begin
        i           = '0;
        j           = '0;
        k           = '0;
        read        = 1'b0;
        write       = 1'b0;
        MemSel      = MEM_SEL_A;
        MAC_or_Size = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        done        = 1'b0;
        unique case (state_q)
`ifdef MM_SEQ_HDR_EN
            StHdr: begin
                // i=0, j=FF: address 0*N+FF+1 wraps to 0, copying A[0] into C[0].
                j           = HDR_IDX;
                read        = 1'b1;
                write       = 1'b1;
                MemSel      = MEM_SEL_C;
                MAC_or_Size = 1'b1;
            end
`endif
            StClr: mac_clr = 1'b1;
            StAcc: begin
                i      = {4'd0, row};
                j      = {4'd0, inr};
                k      = {4'd0, col};
                read   = 1'b1;
                mac_en = 1'b1;
            end
            StWr: begin
                i      = {4'd0, row};
                j      = {4'd0, col};
                write  = 1'b1;
                MemSel = MEM_SEL_C;
            end
            StFin:   done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign err  = err_q;

endmodule
